// File: rtl/instr_pkg.sv
// Field map, opcode constants and FSM state encoding shared by the instruction dispatch slice.
package instr_pkg;

    localparam int FlitWidth   = 82;
    localparam int ValidBitPos = 81;
    localparam int DstPos      = 72;
    localparam int SrcPos      = 63;
    localparam int RankPos     = 54;
    localparam int OpPos       = 32;
    localparam int NodeWidth   = 9;
    localparam int OpWidth     = 4;

    localparam logic [OpWidth-1:0] Gather      = 4'b1011;
    localparam logic [OpWidth-1:0] ShortReduce = 4'b1100;
    localparam logic [OpWidth-1:0] LargeReduce = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        NEXT
    } state_t;

    // Ops whose destination is rewritten to the root node.
    function automatic logic is_root_op(input logic [OpWidth-1:0] op);
        return (op == Gather) || (op == ShortReduce) || (op == LargeReduce);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
module sat_counter #(
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    output logic [CntWidth-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CntWidth{1'b1}})) begin
            count <= count + CntWidth'(1);
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// Read-side engine for instr_fifo: fetch, stamp source/rank, resolve root ops, inject to network.
// Optional stall statistics are built when INSTR_DISPATCH_STALL_EN is defined.
module instr_dispatch #(
    parameter int         FlitWidth = 82,
    parameter logic [8:0] cur_rank  = 9'b0,
    parameter logic [2:0] rank_x    = 3'b0,
    parameter logic [2:0] rank_y    = 3'b0,
    parameter logic [2:0] rank_z    = 3'b0,
    parameter logic [2:0] root_x    = 3'b0,
    parameter logic [2:0] root_y    = 3'b0,
    parameter logic [2:0] root_z    = 3'b0,
    parameter int         CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [FlitWidth-1:0] fifo_out,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [FlitWidth-1:0] flit_out,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic                 busy,
    output logic [CntWidth-1:0]  issued_cnt,
    output logic [CntWidth-1:0]  dropped_cnt,
    output logic [CntWidth-1:0]  stall_cnt
);

    import instr_pkg::*;

    state_t                 state;
    state_t                 next_state;
    logic [FlitWidth-1:0]   stamped;
    logic                   handshake;
    logic                   load_valid;

    assign handshake  = flit_valid && flit_ready;
    assign load_valid = fifo_out[ValidBitPos];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable && !fifo_empty) next_state = FETCH;
            FETCH: next_state = LOAD;
            LOAD:  next_state = load_valid ? SEND : NEXT;
            SEND:  if (handshake) next_state = NEXT;
            NEXT:  next_state = (enable && !fifo_empty) ? FETCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stamped = fifo_out;
        stamped[SrcPos +: NodeWidth]  = {rank_z, rank_y, rank_x};
        stamped[RankPos +: NodeWidth] = cur_rank;
        if (is_root_op(fifo_out[OpPos +: OpWidth])) begin
            stamped[DstPos +: NodeWidth] = {root_z, root_y, root_x};
        end
    end

    // Read strobe is registered so it is high for exactly the FETCH cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd_en <= 1'b0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
        end else begin
            fifo_rd_en <= (next_state == FETCH);
            if (state == LOAD && load_valid) begin
                flit_out   <= stamped;
                flit_valid <= 1'b1;
            end else if (state == SEND && handshake) begin
                flit_valid <= 1'b0;
            end
        end
    end

    sat_counter #(.CntWidth(CntWidth)) u_issued (
        .clk   (clk),
        .rst   (rst),
        .inc   (state == SEND && handshake),
        .count (issued_cnt)
    );

    sat_counter #(.CntWidth(CntWidth)) u_dropped (
        .clk   (clk),
        .rst   (rst),
        .inc   (state == LOAD && !load_valid),
        .count (dropped_cnt)
    );

`ifdef INSTR_DISPATCH_STALL_EN
    sat_counter #(.CntWidth(CntWidth)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (flit_valid && !flit_ready),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed plus randomized bench for instr_dispatch against a field-level reference model.
module tb_instr_dispatch;

    localparam int         flitW   = 82;
    localparam int         cntW    = 4;
    localparam logic [2:0] rankX   = 3'd1;
    localparam logic [2:0] rankY   = 3'd2;
    localparam logic [2:0] rankZ   = 3'd3;
    localparam logic [2:0] rootX   = 3'd4;
    localparam logic [2:0] rootY   = 3'd5;
    localparam logic [2:0] rootZ   = 3'd6;
    localparam logic [8:0] curRank = 9'd5;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic             enable     = 1'b0;
    logic [flitW-1:0] fifo_out   = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [flitW-1:0] flit_out;
    logic             flit_valid;
    logic             flit_ready = 1'b0;
    logic             busy;
    logic [cntW-1:0]  issued_cnt;
    logic [cntW-1:0]  dropped_cnt;
    logic [cntW-1:0]  stall_cnt;

    always #5 clk = ~clk;

    instr_dispatch #(
        .FlitWidth (flitW),
        .cur_rank  (curRank),
        .rank_x    (rankX),
        .rank_y    (rankY),
        .rank_z    (rankZ),
        .root_x    (rootX),
        .root_y    (rootY),
        .root_z    (rootZ),
        .CntWidth  (cntW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_out    (fifo_out),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .flit_out    (flit_out),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .busy        (busy),
        .issued_cnt  (issued_cnt),
        .dropped_cnt (dropped_cnt),
        .stall_cnt   (stall_cnt)
    );

    int               assertCount = 0;
    int               failCount   = 0;
    logic [flitW-1:0] fifoQ[$];
    logic [flitW-1:0] accepted[$];
    int               rdCount     = 0;
    int               rdEmptyViol = 0;
    int               stableViol  = 0;
    int               stallSeen   = 0;
    int               validCycles = 0;
    bit               pendingRead = 1'b0;
    bit               prevHold    = 1'b0;
    logic [flitW-1:0] prevFlit    = '0;
    int               expIssued   = 0;
    int               expDropped  = 0;

    // Observe the interface half a cycle after each edge.
    always @(negedge clk) begin
        pendingRead = fifo_rd_en;
        if (fifo_rd_en) begin
            rdCount++;
            if (fifo_empty) rdEmptyViol++;
        end
        if (flit_valid) validCycles++;
        if (flit_valid && flit_ready) accepted.push_back(flit_out);
        if (flit_valid && !flit_ready) stallSeen++;
        if (prevHold && flit_valid && (flit_out !== prevFlit)) stableViol++;
        prevHold = flit_valid && !flit_ready;
        prevFlit = flit_out;
    end

    // One-cycle-latency FIFO with a registered empty flag.
    always @(posedge clk) begin
        if (pendingRead && fifoQ.size() > 0) begin
            fifo_out <= fifoQ.pop_front();
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [cntW-1:0] sat(input int n);
        int top;
        top = (1 << cntW) - 1;
        return (n >= top) ? cntW'(top) : cntW'(n);
    endfunction

    function automatic logic [cntW-1:0] stallExpect();
`ifdef INSTR_DISPATCH_STALL_EN
        return sat(stallSeen);
`else
        return '0;
`endif
    endfunction

    function automatic logic [flitW-1:0] makeFlit(input logic v, input logic [3:0] op,
                                                  input logic [8:0] dst);
        return {v, dst, 9'($urandom), 9'($urandom), 18'($urandom), op, 32'($urandom)};
    endfunction

    // Reference model: what the network should see for a given FIFO flit.
    function automatic logic [flitW-1:0] expectedFlit(input logic [flitW-1:0] f);
        logic [flitW-1:0] r;
        int               op;
        r  = f;
        op = int'(f[35:32]);
        r[71:63] = 9'(int'(rankZ) * 64 + int'(rankY) * 8 + int'(rankX));
        r[62:54] = curRank;
        if (op == 11 || op == 12 || op == 13) begin
            r[80:72] = 9'(int'(rootZ) * 64 + int'(rootY) * 8 + int'(rootX));
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [flitW-1:0] observed,
                               input logic [flitW-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [flitW-1:0] f);
        fifoQ.push_back(f);
        if (f[81]) expIssued++;
        else expDropped++;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        for (int c = 0; c < maxCycles; c++) begin
            stepCycle();
            if (!busy && (!enable || (fifo_empty && fifoQ.size() == 0))) break;
        end
        checkOutput({tag, "_idle"}, flitW'(busy), '0);
    endtask

    task automatic waitValid(input int maxCycles, input string tag);
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (flit_valid) break;
        end
        checkOutput({tag, "_valid"}, flitW'(flit_valid), flitW'(1));
    endtask

    initial begin
        logic [flitW-1:0] f;
        logic [flitW-1:0] g;
        logic [flitW-1:0] expQ[$];
        int               rdBase;
        int               accBase;
        int               valBase;

        $display("[TB] start");
        repeat (3) stepCycle();
        checkOutput("reset_flit_out", flit_out, '0);
        checkOutput("reset_flit_valid", flitW'(flit_valid), '0);
        checkOutput("reset_rd_en", flitW'(fifo_rd_en), '0);
        checkOutput("reset_busy", flitW'(busy), '0);
        checkOutput("reset_issued", flitW'(issued_cnt), '0);
        checkOutput("reset_dropped", flitW'(dropped_cnt), '0);
        checkOutput("reset_stall", flitW'(stall_cnt), '0);
        rst = 1'b1;
        stepCycle();

        // Plain op, destination passes through.
        rdBase = rdCount; accBase = accepted.size();
        f = makeFlit(1'b1, 4'b0111, 9'h0AB);
        applyStimulus(f);
        flit_ready = 1'b1;
        enable     = 1'b1;
        waitIdle(50, "t1");
        checkOutput("t1_rd_pulses", flitW'(rdCount - rdBase), flitW'(1));
        checkOutput("t1_accepted", flitW'(accepted.size() - accBase), flitW'(1));
        g = accepted[accepted.size() - 1];
        checkOutput("t1_flit", g, expectedFlit(f));
        checkOutput("t1_src", flitW'(g[71:63]), flitW'(9'o321));
        checkOutput("t1_rank", flitW'(g[62:54]), flitW'(5));
        checkOutput("t1_dst", flitW'(g[80:72]), flitW'(9'h0AB));
        checkOutput("t1_payload", flitW'(g[31:0]), flitW'(f[31:0]));
        checkOutput("t1_issued", flitW'(issued_cnt), flitW'(1));

        // Root-directed op.
        f = makeFlit(1'b1, 4'b1100, 9'($urandom));
        applyStimulus(f);
        waitIdle(50, "t2");
        g = accepted[accepted.size() - 1];
        checkOutput("t2_dst_root", flitW'(g[80:72]), flitW'(9'o654));
        checkOutput("t2_flit", g, expectedFlit(f));

        // Invalid flit is dropped.
        valBase = validCycles; accBase = accepted.size();
        f = makeFlit(1'b0, 4'b0010, 9'($urandom));
        applyStimulus(f);
        waitIdle(50, "t3");
        checkOutput("t3_no_valid", flitW'(validCycles - valBase), '0);
        checkOutput("t3_no_accept", flitW'(accepted.size() - accBase), '0);
        checkOutput("t3_dropped", flitW'(dropped_cnt), flitW'(1));
        checkOutput("t3_issued", flitW'(issued_cnt), flitW'(2));

        // Back-pressure for ten cycles.
        flit_ready = 1'b0;
        rdBase = rdCount;
        f = makeFlit(1'b1, 4'b1011, 9'($urandom));
        applyStimulus(f);
        stepCycle();
        waitValid(50, "t4");
        repeat (9) @(negedge clk);
        stepCycle();
        flit_ready = 1'b1;
        waitIdle(50, "t4");
        checkOutput("t4_rd_pulses", flitW'(rdCount - rdBase), flitW'(1));
        checkOutput("t4_stable", flitW'(stableViol), '0);
`ifdef INSTR_DISPATCH_STALL_EN
        checkOutput("t4_stall", flitW'(stall_cnt), flitW'(10));
`else
        checkOutput("t4_stall", flitW'(stall_cnt), '0);
`endif
        checkOutput("t4_issued", flitW'(issued_cnt), flitW'(3));
        checkOutput("t4_flit", accepted[accepted.size() - 1], expectedFlit(f));

        // Enable dropped during the second of three queued flits.
        flit_ready = 1'b0;
        rdBase = rdCount; accBase = accepted.size();
        expQ.delete();
        for (int i = 0; i < 3; i++) begin
            f = makeFlit(1'b1, 4'($urandom), 9'($urandom));
            applyStimulus(f);
            expQ.push_back(expectedFlit(f));
        end
        stepCycle();
        waitValid(50, "t5a");
        stepCycle();
        flit_ready = 1'b1;
        stepCycle();
        flit_ready = 1'b0;
        waitValid(50, "t5b");
        enable = 1'b0;
        stepCycle();
        flit_ready = 1'b1;
        waitIdle(50, "t5");
        repeat (3) stepCycle();
        checkOutput("t5_rd_pulses", flitW'(rdCount - rdBase), flitW'(2));
        checkOutput("t5_accepted", flitW'(accepted.size() - accBase), flitW'(2));
        checkOutput("t5_busy", flitW'(busy), '0);
        checkOutput("t5_fifo_nonempty", flitW'(fifo_empty), '0);
        checkOutput("t5_flit0", accepted[accBase], expQ[0]);
        checkOutput("t5_flit1", accepted[accBase + 1], expQ[1]);
        enable = 1'b1;
        waitIdle(50, "t5drain");
        checkOutput("t5_flit2", accepted[accepted.size() - 1], expQ[2]);
        checkOutput("t5_issued", flitW'(issued_cnt), flitW'(sat(expIssued)));
        checkOutput("t5_stall", flitW'(stall_cnt), flitW'(stallExpect()));

        // Asynchronous reset while a flit is waiting for the network.
        flit_ready = 1'b0;
        f = makeFlit(1'b1, 4'b0001, 9'($urandom));
        applyStimulus(f);
        stepCycle();
        waitValid(50, "t6");
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("t6_valid_cleared", flitW'(flit_valid), '0);
        checkOutput("t6_issued_cleared", flitW'(issued_cnt), '0);
        checkOutput("t6_dropped_cleared", flitW'(dropped_cnt), '0);
        checkOutput("t6_stall_cleared", flitW'(stall_cnt), '0);
        checkOutput("t6_busy_cleared", flitW'(busy), '0);
        expIssued = 0; expDropped = 0; stallSeen = 0;
        stepCycle();
        rst = 1'b1;
        flit_ready = 1'b1;
        rdBase = rdCount;
        f = makeFlit(1'b1, 4'b1101, 9'($urandom));
        applyStimulus(f);
        waitIdle(50, "t6");
        checkOutput("t6_refetch", flitW'(rdCount - rdBase), flitW'(1));
        checkOutput("t6_issued", flitW'(issued_cnt), flitW'(1));
        checkOutput("t6_flit", accepted[accepted.size() - 1], expectedFlit(f));

        // Randomized traffic with random back-pressure; counters saturate here.
        accBase = accepted.size();
        expQ.delete();
        for (int i = 0; i < 24; i++) begin
            f = makeFlit($urandom_range(0, 3) != 0, 4'($urandom), 9'($urandom));
            applyStimulus(f);
            if (f[81]) expQ.push_back(expectedFlit(f));
        end
        for (int c = 0; c < 3000; c++) begin
            stepCycle();
            flit_ready = ($urandom_range(0, 3) != 0);
            if (!busy && fifo_empty && fifoQ.size() == 0) break;
        end
        flit_ready = 1'b1;
        repeat (2) stepCycle();
        checkOutput("t7_idle", flitW'(busy), '0);
        checkOutput("t7_count", flitW'(accepted.size() - accBase), flitW'(expQ.size()));
        for (int i = 0; i < expQ.size() && (accBase + i) < accepted.size(); i++) begin
            checkOutput($sformatf("t7_flit%0d", i), accepted[accBase + i], expQ[i]);
        end
        checkOutput("t7_issued_sat", flitW'(issued_cnt), flitW'(sat(expIssued)));
        checkOutput("t7_dropped_sat", flitW'(dropped_cnt), flitW'(sat(expDropped)));
        checkOutput("t7_stall", flitW'(stall_cnt), flitW'(stallExpect()));
        checkOutput("rd_while_empty", flitW'(rdEmptyViol), '0);
        checkOutput("hold_stable", flitW'(stableViol), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
